data_mem_responder: RTL and testbench

//   Memory-side responder for the pipeline's data port. Takes M-stage load/store

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_mux.sv | 35 +++
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and request payload for the data-memory responder.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN (memory-mapped cycle counter).
package dmem_pkg;

    // Latency down-counter width; covers LATENCY up to 15
    localparam int unsigned CNT_W = 4;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Word-load address that returns the cycle counter when enabled
    localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FFFC;

    // Request captured on acceptance
    typedef struct packed {
        logic        write;
        logic        is_byte;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-lane helper: zero-extended byte extract for loads and
// read-modify-write merge for byte stores (little-endian lanes).
module dmem_lane_mux (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] ld_ext_c_o,
    output logic [31:0] st_merge_c_o
);

    // Select/replace the addressed lane; other lanes pass through
    always_comb begin
        ld_ext_c_o   = '0;
        st_merge_c_o = word_i;
        case (lane_i)
            2'd0: begin
                ld_ext_c_o         = {24'b0, word_i[7:0]};
                st_merge_c_o[7:0]  = byte_i;
            end
            2'd1: begin
                ld_ext_c_o         = {24'b0, word_i[15:8]};
                st_merge_c_o[15:8] = byte_i;
            end
            2'd2: begin
                ld_ext_c_o          = {24'b0, word_i[23:16]};
                st_merge_c_o[23:16] = byte_i;
            end
            default: begin
                ld_ext_c_o          = {24'b0, word_i[31:24]};
                st_merge_c_o[31:24] = byte_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: accepts one load/store, completes it after
// LATENCY cycles with a one-cycle MemReady pulse, flags misaligned or
// out-of-range accesses. Stores commit on the edge leaving the response cycle.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN (cycle counter readable by a
// word load of MMIO_CNT_ADDR; without it that address faults like any other).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWriteM,
    input  logic        MByte,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemFault
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    dmem_req_t        in_req_c, src_c;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx_c;
    logic [31:0]      word_c, ld_ext_c, st_merge_c, rsp_data_c, wr_data_c;
    logic             misalign_c, oor_c, mmio_c, rsp_fault_c, mem_we_c;

    // Incoming request payload
    always_comb begin
        in_req_c.write   = MemWriteM;
        in_req_c.is_byte = MByte;
        in_req_c.addr    = AddrM;
        in_req_c.wdata   = WriteDataM;
    end

    // In IDLE the response is built from live inputs (LATENCY==1 path), else from the latch
    assign src_c = (state_q == ST_IDLE) ? in_req_c : req_q;

    assign idx_c      = src_c.addr[IDX_W+1:2];
    assign word_c     = mem_q[idx_c];
    assign misalign_c = !src_c.is_byte && (src_c.addr[1:0] != 2'b00);
    assign oor_c      = |src_c.addr[31:IDX_W+2];

    dmem_lane_mux u_lane_mux (
        .word_i       (word_c),
        .lane_i       (src_c.addr[1:0]),
        .byte_i       (src_c.wdata[7:0]),
        .ld_ext_c_o   (ld_ext_c),
        .st_merge_c_o (st_merge_c)
    );

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    logic [31:0] snap_q, snap_d;
    logic [31:0] snap_src_c;

    // Free-running cycle counter
    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_q + 32'd1;
    end

    // Counter snapshot taken when a request is accepted
    always_comb begin
        snap_d = snap_q;
        if (state_q == ST_IDLE && MemReq) snap_d = cyc_q;
    end

    // Snapshot register
    always_ff @(posedge clk) begin
        if (reset) snap_q <= '0;
        else       snap_q <= snap_d;
    end

    assign snap_src_c = (state_q == ST_IDLE) ? cyc_q : snap_q;
    assign mmio_c     = (src_c.addr == MMIO_CNT_ADDR) && !src_c.is_byte;
`else
    assign mmio_c = 1'b0;
`endif

    assign rsp_fault_c = misalign_c || (oor_c && !mmio_c);

    // Response data: zero on faults and stores, else counter / byte lane / word
    always_comb begin
        rsp_data_c = '0;
        if (!rsp_fault_c && !src_c.write) begin
`ifdef DMEM_CYCLE_COUNTER_EN
            if (mmio_c)               rsp_data_c = snap_src_c;
            else if (src_c.is_byte)   rsp_data_c = ld_ext_c;
            else                      rsp_data_c = word_c;
`else
            if (src_c.is_byte)        rsp_data_c = ld_ext_c;
            else                      rsp_data_c = word_c;
`endif
        end
    end

    // Store commit when leaving RESP; faulted, MMIO and reset-aborted stores are dropped
    assign wr_data_c = src_c.is_byte ? st_merge_c : src_c.wdata;
    assign mem_we_c  = (state_q == ST_RESP) && !reset && src_c.write && !fault_q && !mmio_c;

    // Next-state and response-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (MemReq) begin
                    req_d = in_req_c;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        fault_d = rsp_fault_c;
                        rdata_d = rsp_data_c;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    fault_d = rsp_fault_c;
                    rdata_d = rsp_data_c;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Data RAM (contents survive reset)
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[idx_c] <= wr_data_c;
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemFault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random accesses against a
// word-array reference model. Instance dut uses LATENCY=2, dut1 LATENCY=1.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] MMIO  = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0, wr0, byt0, rdy0, flt0;
    logic [31:0] addr0, wd0, rd0;
    logic        req1, wr1, byt1, rdy1, flt1;
    logic [31:0] addr1, wd1, rd1;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MemReq(req0), .MemWriteM(wr0), .MByte(byt0),
        .AddrM(addr0), .WriteDataM(wd0), .ReadData(rd0), .MemReady(rdy0), .MemFault(flt0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .MemReq(req1), .MemWriteM(wr1), .MByte(byt1),
        .AddrM(addr1), .WriteDataM(wd1), .ReadData(rd1), .MemReady(rdy1), .MemFault(flt1)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model [2][DEPTH];
    logic [31:0] tb_cyc;

    // Reference cycle count: cleared by reset, +1 per clock
    always @(posedge clk) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_fault(input logic byt, input logic [31:0] a);
        if (!byt && a[1:0] != 2'b00) return 1'b1;
`ifdef DMEM_CYCLE_COUNTER_EN
        if (a == MMIO && !byt) return 1'b0;
`endif
        return (a >= DEPTH * 4);
    endfunction

    task automatic drive(input int inst, input logic rq, input logic wr, input logic byt,
                         input logic [31:0] a, input logic [31:0] wd);
        if (inst == 0) begin
            req0 = rq; wr0 = wr; byt0 = byt; addr0 = a; wd0 = wd;
        end else begin
            req1 = rq; wr1 = wr; byt1 = byt; addr1 = a; wd1 = wd;
        end
    endtask

    task automatic drop_req(input int inst);
        if (inst == 0) req0 = 1'b0;
        else           req1 = 1'b0;
    endtask

    // One access, started at a negedge with the DUT idle; returns at the negedge of the idle cycle after the response
    task automatic access(input int inst, input logic wr, input logic byt, input logic [31:0] a,
                          input logic [31:0] wd, input logic drop, output logic [31:0] got);
        int lat;
        int seen;
        int seen_k;
        logic [31:0] obs_d;
        logic        obs_f;
        logic [31:0] cyc_e0;
        logic        f;
        logic [31:0] ed;
        int          idx;
        int          sh;
        lat    = (inst == 0) ? 2 : 1;
        seen   = 0;
        seen_k = -1;
        obs_d  = '0;
        obs_f  = 1'b0;
        drive(inst, 1'b1, wr, byt, a, wd);
        cyc_e0 = tb_cyc;
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1 && drop) drop_req(inst);
            if ((inst == 0) ? rdy0 : rdy1) begin
                seen++;
                seen_k = k;
                obs_d  = (inst == 0) ? rd0 : rd1;
                obs_f  = (inst == 0) ? flt0 : flt1;
                drop_req(inst);
            end
        end
        drop_req(inst);

        f   = exp_fault(byt, a);
        idx = int'((a >> 2) % DEPTH);
        sh  = 8 * int'(a[1:0]);
        ed  = '0;
        if (!f && !wr) begin
`ifdef DMEM_CYCLE_COUNTER_EN
            if (a == MMIO && !byt) ed = cyc_e0;
            else
`endif
            if (byt) ed = (model[inst][idx] >> sh) & 32'hFF;
            else     ed = model[inst][idx];
        end
        if (!f && wr && !(a == MMIO && !byt)) begin
            if (byt) model[inst][idx] = (model[inst][idx] & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh);
            else     model[inst][idx] = wd;
        end

        chk($sformatf("latency[%0d]@%h", inst, a), 32'(seen_k), 32'(lat));
        chk($sformatf("pulses[%0d]@%h", inst, a), 32'(seen), 32'd1);
        chk($sformatf("fault[%0d]@%h", inst, a), {31'b0, obs_f}, {31'b0, f});
        if (!wr) chk($sformatf("rdata[%0d]@%h", inst, a), obs_d, ed);
        got = obs_d;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] a;
        logic        wr;
        logic        byt;
        int          inst;
        int          r;
        int          pulses;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_ready0", {31'b0, rdy0}, 32'd0);
        chk("rst_fault0", {31'b0, flt0}, 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_ready1", {31'b0, rdy1}, 32'd0);
        chk("rst_fault1", {31'b0, flt1}, 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        reset = 1'b0;

        // Give every RAM word a known value in both instances
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < int'(DEPTH); w++)
                access(i, 1'b1, 1'b0, 32'(w * 4), $urandom, 1'b0, got);

        // Word store then load
        access(0, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 1'b0, got);
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, got);
        chk("word_load_0x10", got, 32'h1234_5678);

        // Byte store merges into one lane
        access(0, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 1'b0, got);
        access(0, 1'b1, 1'b1, 32'h13, 32'hFFFF_FFAB, 1'b0, got);
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, got);
        chk("byte_merge", got, 32'hAB11_1111);
        access(0, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0, got);
        chk("byte_load", got, 32'h0000_00AB);
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, got);
        chk("byte_load_lane0", got, 32'h0000_0011);

        // Faults: misaligned word load, out-of-range store leaves RAM alone
        access(0, 1'b0, 1'b0, 32'h12, 32'h0, 1'b0, got);
        chk("misalign_rdata", got, 32'h0);
        v1 = model[0][0];
        access(0, 1'b1, 1'b0, 32'h1000, 32'hCAFE_F00D, 1'b0, got);
        access(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, got);
        chk("oor_store_no_alias", got, v1);

        // Reset while BUSY aborts a store
        v1 = model[0][8];
        drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drop_req(0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (4) begin
            if (rdy0) pulses++;
            @(negedge clk);
        end
        chk("abort_no_ready", 32'(pulses), 32'd0);
        chk("abort_rdata", rd0, 32'd0);
        access(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, got);
        chk("abort_store_dropped", got, v1);

        // MemReq dropped after acceptance still completes
        access(0, 1'b1, 1'b0, 32'h24, 32'h5A5A_0001, 1'b1, got);
        access(0, 1'b0, 1'b0, 32'h24, 32'h0, 1'b1, got);
        chk("drop_load", got, 32'h5A5A_0001);

        // LATENCY=1 instance
        access(1, 1'b1, 1'b0, 32'h3C, 32'h0BAD_CAFE, 1'b0, got);
        access(1, 1'b0, 1'b0, 32'h3C, 32'h0, 1'b1, got);
        chk("lat1_load", got, 32'h0BAD_CAFE);
        access(1, 1'b0, 1'b1, 32'h3E, 32'h0, 1'b0, got);
        chk("lat1_byte", got, 32'h0000_00AD);

        // Counter address
`ifdef DMEM_CYCLE_COUNTER_EN
        access(0, 1'b0, 1'b0, MMIO, 32'h0, 1'b0, v1);
        repeat (7) @(negedge clk);
        access(0, 1'b0, 1'b0, MMIO, 32'h0, 1'b0, v2);
        chk("cnt_delta", v2 - v1, 32'd10);
        access(0, 1'b0, 1'b1, MMIO, 32'h0, 1'b0, got);
        access(0, 1'b1, 1'b0, MMIO, 32'h1234, 1'b0, got);
`else
        access(0, 1'b0, 1'b0, MMIO, 32'h0, 1'b0, got);
        chk("mmio_rdata", got, 32'h0);
        v2 = 32'h0;
`endif

        // Random mix of loads/stores, byte/word, in/out of range
        for (int n = 0; n < 200; n++) begin
            inst = (n % 4 == 3) ? 1 : 0;
            r    = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            byt  = 1'($urandom_range(0, 1));
            if (r <= 6) begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                if (byt || r == 6) a = a | 32'($urandom_range(0, 3));
            end else if (r == 7) begin
                a = $urandom;
            end else begin
                a = MMIO;
            end
            access(inst, wr, byt, a, $urandom, 1'($urandom_range(0, 1)), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something stalls
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
